// File: rtl/dot_mac_pkg.sv
// dot_mac_pkg
// Shared definitions for the dot-product MAC scheduler:
//   - state_t   : scheduler FSM state encoding
//   - NIBBLES   : number of nibble lanes per 32-bit word
//   - X_LSB / Y_LSB / NIB_W : where the x and y nibbles live inside a word
//   - nibble_product : zero-extended 4x4 product of lane k of a word
package dot_mac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_ACC,
        S_FIN,
        S_RESP
    } state_t;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 16;

    // x operands occupy the low half-word, y operands the high half-word,
    // lane k of each sitting at the same nibble offset.
    function automatic logic [7:0] nibble_product(input logic [31:0] word, input int k);
        logic [3:0] x;
        logic [3:0] y;
        x = word[X_LSB + k*NIB_W +: NIB_W];
        y = word[Y_LSB + k*NIB_W +: NIB_W];
        return {4'b0000, x} * {4'b0000, y};
    endfunction

endpackage

// File: rtl/dot_mac_arbiter.sv
// dot_mac_arbiter
// Picks one requester out of a valid vector.
// Build option: define DOT_MAC_ROUND_ROBIN_EN for round-robin arbitration
// (search starts at an internal pointer that moves past each finished job);
// otherwise fixed priority, lowest index wins, and no pointer exists.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   i_req_valid   : NREQ request lines
//   i_advance     : a job has completed this cycle
//   i_done_id     : requester that owned the completed job
//   o_gnt         : index of the selected requester
//   o_any         : at least one request present
module dot_mac_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req_valid,
    input  logic            i_advance,
    input  logic [IDW-1:0]  i_done_id,
    output logic [IDW-1:0]  o_gnt,
    output logic            o_any
);

    assign o_any = |i_req_valid;

`ifdef DOT_MAC_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr;

    // The pointer lands on the requester just after the one that finished,
    // so it becomes the highest-priority candidate for the next job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= IDW'((int'(i_done_id) + 1) % NREQ);
        end
    end

    always_comb begin
        logic w_found;
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && i_req_valid[idx]) begin
                o_gnt   = IDW'(idx);
                w_found = 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_advance, i_done_id};

    // Scanning downward lets the lowest valid index overwrite the rest.
    always_comb begin
        o_gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                o_gnt = IDW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/dot_mac_scheduler.sv
// dot_mac_scheduler
// Shares one 4x4 multiply / 8-bit accumulate datapath among NREQ requesters.
// A granted requester streams LEN words; each word yields four nibble
// products accumulated into S0..S3, and the job returns
// W = (S0-S1)+(S2-S3) mod 256 tagged with the requester id.
// Build option: DOT_MAC_ROUND_ROBIN_EN (round-robin arbitration, handled
// inside dot_mac_arbiter); default is fixed priority.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-requester word valid
//   req_data   : per-requester 32-bit words, requester i at [32*i +: 32]
//   req_ready  : per-requester word accept (only the granted one, in LOAD)
//   res_valid / res_ready : result handshake
//   res_data   : W mod 256
//   res_id     : requester that owned the job
//   busy       : high whenever not idle
module dot_mac_scheduler
    import dot_mac_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LEN  = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_data,
    output logic [IDW-1:0]     res_id,
    output logic               busy
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_gnt;
    logic [IDW-1:0]  w_arbGnt;
    logic            w_arbAny;
    logic [31:0]     r_word;
    logic [31:0]     w_selWord;
    logic            w_gntValid;
    logic            w_lastWord;
    logic            w_resAccept;
    logic [7:0]      r_m [NIBBLES];
    logic [7:0]      r_s [NIBBLES];
    logic [7:0]      r_w;
    logic [CW-1:0]   r_cnt;

    assign w_selWord   = req_data[int'(r_gnt)*32 +: 32];
    assign w_gntValid  = req_valid[r_gnt];
    assign w_lastWord  = (r_cnt == CW'(LEN - 1));
    assign w_resAccept = (r_state == S_RESP) && res_ready;

    dot_mac_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_advance   (w_resAccept),
        .i_done_id   (r_gnt),
        .o_gnt       (w_arbGnt),
        .o_any       (w_arbAny)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arbAny)   w_next = S_LOAD;
            S_LOAD:  if (w_gntValid) w_next = S_MUL0;
            S_MUL0:  w_next = S_MUL1;
            S_MUL1:  w_next = S_MUL2;
            S_MUL2:  w_next = S_MUL3;
            S_MUL3:  w_next = S_ACC;
            S_ACC:   w_next = w_lastWord ? S_FIN : S_LOAD;
            S_FIN:   w_next = S_RESP;
            S_RESP:  if (res_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (r_state == S_LOAD) && (r_gnt == IDW'(i));
        end
        res_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE);
    end

    assign res_data = r_w;
    assign res_id   = r_gnt;

    // Grant is captured once in IDLE and held until the result is taken, so
    // res_id stays stable through RESP and other requesters are locked out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= '0;
            r_word <= '0;
            r_w    <= '0;
            r_cnt  <= '0;
            for (int k = 0; k < NIBBLES; k++) begin
                r_m[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arbAny) begin
                        r_gnt <= w_arbGnt;
                    end
                end
                S_LOAD: begin
                    if (w_gntValid) begin
                        r_word <= w_selWord;
                    end
                end
                S_MUL0: r_m[0] <= nibble_product(r_word, 0);
                S_MUL1: r_m[1] <= nibble_product(r_word, 1);
                S_MUL2: r_m[2] <= nibble_product(r_word, 2);
                S_MUL3: r_m[3] <= nibble_product(r_word, 3);
                S_ACC: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        r_s[k] <= r_s[k] + r_m[k];
                    end
                    if (!w_lastWord) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    r_w <= (r_s[0] - r_s[1]) + (r_s[2] - r_s[3]);
                end
                S_RESP: begin
                    // Clearing on acceptance leaves the next job starting
                    // from zero sums; r_w is kept so res_data only changes
                    // when a new result is produced.
                    if (res_ready) begin
                        r_cnt <= '0;
                        for (int k = 0; k < NIBBLES; k++) begin
                            r_m[k] <= '0;
                            r_s[k] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_mac_scheduler.sv
// tb_dot_mac_scheduler
// Directed and randomized jobs against a plain-arithmetic reference of the
// nibble dot product, plus cycle-accurate checks of result latency, grant
// exclusivity, result stability under backpressure and reset abort.
module tb_dot_mac_scheduler;

    localparam int NREQ = 2;
    localparam int LEN  = 4;
    localparam int IDW  = $clog2(NREQ);

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [7:0]         res_data;
    logic [IDW-1:0]     res_id;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] jobWords [LEN];

    dot_mac_scheduler #(
        .NREQ (NREQ),
        .LEN  (LEN),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: integer lane sums over all words, reduced mod 256 at the end.
    function automatic logic [7:0] modelW();
        int s [4];
        for (int k = 0; k < 4; k++) s[k] = 0;
        for (int w = 0; w < LEN; w++) begin
            for (int k = 0; k < 4; k++) begin
                s[k] += int'((jobWords[w] >> (4*k)) & 32'hF) *
                        int'((jobWords[w] >> (16 + 4*k)) & 32'hF);
            end
        end
        return 8'((s[0] - s[1] + s[2] - s[3]) & 255);
    endfunction

    function automatic void fillWords(input logic [31:0] w);
        for (int i = 0; i < LEN; i++) jobWords[i] = w;
    endfunction

    function automatic void fillRandom();
        for (int i = 0; i < LEN; i++) jobWords[i] = $urandom;
    endfunction

    // Runs one job from requester id using jobWords. Called right after a
    // falling edge with the DUT idle. stallWord/stallLen drop valid while the
    // DUT waits for that word; respStall holds res_ready low after the result
    // appears. abortAt > 0 asserts reset at that cycle and returns.
    task automatic applyStimulus(input int id, input int stallWord, input int stallLen,
                                 input int respStall, input int abortAt);
        logic [7:0] expW;
        int wi, cyc, stallLeft, firstAccept, firstValid, held;
        logic done;
        expW        = modelW();
        wi          = 0;
        cyc         = 0;
        stallLeft   = stallLen;
        firstAccept = -1;
        firstValid  = -1;
        held        = 0;
        done        = 1'b0;
        checkOutput("idle_before_job", busy, 0);
        req_valid[id]            = 1'b1;
        req_data[id*32 +: 32]    = jobWords[0];
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == abortAt) begin
                rst = 1'b0;
                return;
            end
            if (req_ready != '0) begin
                checkOutput("ready_only_owner", req_ready, 32'(1) << id);
            end
            if (req_ready[id]) begin
                if (wi == stallWord && stallLeft > 0) begin
                    req_valid[id] = 1'b0;
                    stallLeft--;
                end else begin
                    req_valid[id]         = 1'b1;
                    req_data[id*32 +: 32] = jobWords[wi];
                    if (firstAccept < 0) firstAccept = cyc;
                    wi++;
                end
            end else if (wi < LEN) begin
                req_valid[id]         = 1'b1;
                req_data[id*32 +: 32] = jobWords[wi];
            end else begin
                req_valid[id] = 1'b0;
            end
            if (res_valid) begin
                if (firstValid < 0) begin
                    firstValid = cyc;
                    checkOutput("first_accept_cycle", firstAccept, 1);
                    checkOutput("res_valid_cycle", firstValid, 6*LEN + 2 + stallLen);
                    checkOutput("res_data", res_data, expW);
                    checkOutput("res_id", res_id, id);
                end else begin
                    checkOutput("res_data_stable", res_data, expW);
                    checkOutput("res_id_stable", res_id, id);
                end
                if (held < respStall) begin
                    res_ready = 1'b0;
                    held++;
                end else begin
                    res_ready = 1'b1;
                    done      = 1'b1;
                end
            end
        end
        if (!done) checkOutput("job_timeout", 0, 1);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("res_valid_after_accept", res_valid, 0);
        checkOutput("idle_after_accept", busy, 0);
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [7:0]  exp0, exp1;
        int          nres;
        int          expIds [4];
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_res_data", res_data, 0);
        checkOutput("reset_res_id", res_id, 0);
        checkOutput("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Both requesters valid continuously with constant words.
        d0 = $urandom;
        d1 = $urandom;
        fillWords(d0); exp0 = modelW();
        fillWords(d1); exp1 = modelW();
`ifdef DOT_MAC_ROUND_ROBIN_EN
        expIds = '{0, 1, 0, 1};
`else
        expIds = '{0, 0, 0, 0};
`endif
        req_data  = {d1, d0};
        req_valid = 2'b11;
        res_ready = 1'b1;
        nres      = 0;
        for (int c = 0; c < 300 && nres < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                checkOutput("multi_single_ready", 32'($countones(req_ready)), 1);
            end
            if (res_valid) begin
                checkOutput("multi_res_id", res_id, expIds[nres]);
                checkOutput("multi_res_data", res_data, (expIds[nres] == 0) ? exp0 : exp1);
                nres++;
                if (nres == 4) req_valid = '0;
            end
        end
        checkOutput("multi_result_count", nres, 4);
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        checkOutput("multi_idle", busy, 0);

        // Directed values: plain sum, positive wrap, negative wrap.
        fillWords(32'h0003_0002);
        checkOutput("model_0x18", modelW(), 8'h18);
        applyStimulus(0, -1, 0, 0, 0);
        fillWords(32'h000F_000F);
        checkOutput("model_0x84", modelW(), 8'h84);
        applyStimulus(0, -1, 0, 0, 0);
        fillWords(32'h00F0_00F0);
        checkOutput("model_0x7C", modelW(), 8'h7C);
        applyStimulus(0, -1, 0, 0, 0);

        // Random jobs, including input stall and result backpressure.
        fillRandom();
        applyStimulus(1, -1, 0, 0, 0);
        fillRandom();
        applyStimulus(0, 2, 3, 5, 0);
        fillRandom();
        applyStimulus(1, 1, 2, 3, 0);

        // Abort during MUL2 of the third word, then a fresh job.
        fillRandom();
        applyStimulus(1, -1, 0, 0, 16);
        #1;
        checkOutput("abort_req_ready", req_ready, 0);
        checkOutput("abort_res_valid", res_valid, 0);
        checkOutput("abort_res_data", res_data, 0);
        checkOutput("abort_res_id", res_id, 0);
        checkOutput("abort_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fillRandom();
        applyStimulus(0, -1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_mac_scheduler.md
# dot_mac_scheduler

Job-level scheduler that shares one 4x4-bit multiply / 8-bit accumulate datapath among NREQ requesters. Each requester streams LEN 32-bit words. The block arbitrates per job and sequences four nibble products per word into four running sums. It then returns W = (S0−S1)+(S2−S3) on a valid/ready result port tagged with the requester index. It sits between the per-requester word sources and downstream result consumers, replacing fixed single-program sequencing with a shared, handshaked engine.

## Interface
- NREQ, 2, number of requesters (≥2)
- LEN, 4, words per job (≥1)
- IDW, $clog2(NREQ), requester-id width (derived)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i presents a word
- req_data  in  NREQ×32  word from requester i
- req_ready  out  NREQ  word from requester i accepted this cycle when valid&ready
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  W, mod 256
- res_id  out  IDW  requester that owned the job
- busy  out  1  high in every state except IDLE

## Operation
- Word nibble map: x0..x3 = [3:0],[7:4],[11:8],[15:12]; y0..y3 = [19:16],[23:20],[27:24],[31:28]. Product Mk = xk·yk, 8 bits, zero-extended operands.
- FSM states: IDLE, LOAD, MUL0, MUL1, MUL2, MUL3, ACC, FIN, RESP.
- IDLE: if any req_valid, arbiter picks gnt, latches it, → LOAD; else stay.
- LOAD: req_ready[gnt]=1 only; all other req_ready=0. On req_valid[gnt], capture word, → MUL0. Else stay (stall, no timeout).
- MULk: Mk_reg ← xk·yk; → next MUL; MUL3 → ACC.
- ACC: Sk ← Sk + Mk_reg, all four in parallel, wrap mod 256. If word_cnt==LEN−1 → FIN, else word_cnt++, → LOAD.
- FIN: w_reg ← (S0−S1)+(S2−S3) mod 256; → RESP.
- RESP: res_valid=1; res_data=w_reg, res_id=gnt, both stable until accepted. On res_ready: clear S0..S3, M0..M3, word_cnt; advance arbitration pointer; → IDLE.
- Grant is held for the whole job. Requests from other requesters wait and never see req_ready during that job.
- Reset: async assertion forces IDLE immediately. req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, all S/M/word_cnt/w_reg=0, pointer=0. A job in flight is discarded. Exit to IDLE on the first clock after deassertion.

## Timing
- Per word, no stalls: 6 cycles (LOAD, MUL0–3, ACC).
- IDLE request cycle = cycle 0, no stalls: first accept at 1. res_valid is first high at cycle 6·LEN+2 (26 for LEN=4).
- Each LOAD stall cycle adds one cycle. res_ready low holds RESP indefinitely.
- A request arriving during RESP is not considered until the following IDLE cycle. The minimum gap between jobs is 1 IDLE cycle.

## Configuration
- DOT_MAC_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at pointer. After each completed job, pointer = (gnt+1) mod NREQ.
- Not defined: fixed priority, lowest requester index wins. The pointer logic is absent.

## Structure
- Shared package dot_mac_pkg: state enum type; NIBBLES=4 constant; nibble-slice localparams.
- Sub-module dot_mac_arbiter: req_valid vector + pointer → one-hot/indexed grant. This is the only place the macro appears.

## Test plan
- Single job, req0 words all 0x0003_0002, LEN=4 → res_data=0x18, res_id=0, res_valid at cycle 26.
- req0 words 0x000F_000F ×4 → S0 wraps to 0x84, res_data=0x84. Then req0 words 0x00F0_00F0 ×4 → res_data=0x7C (negative wrap).
- Both requesters valid continuously with RR enabled → results ordered id 0,1,0,1. Without the macro → id 0 only while req0 stays valid.
- req_valid[gnt] dropped for 3 cycles mid-job, res_ready held low 5 cycles → result value unchanged, res_valid at cycle 29 and held stable through the stall.
- Reset asserted during MUL2 of word 2 → outputs zero immediately. A new job after release yields a correct fresh result with no residue from the aborted job.
